spi_multi_motor_ctrl: RTL and testbench

//  Multi-channel successor of the single-drive PMD901 SPI path: one SPI master that refreshes
//  NUM_CH motor drivers round-robin over a shared sclk/mosi with one cs_n per channel.

---
 rtl/spi_multi_pkg.sv | 18 +
 rtl/spi_multi_motor_ctrl_tick.sv | 30 +++
 rtl/spi_multi_motor_ctrl.sv | 174 +++++++++++++++++
 tb/tb_spi_multi_motor_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_multi_pkg.sv
// Shared types and width helpers for the multi-channel PMD901 SPI master.
package spi_multi_pkg;

  typedef enum logic [1:0] {GAP, SETUP, SHIFT, HOLD} spi_state_e;

  localparam int DEF_TICK_W = $clog2(8) + 1;
  localparam int DEF_GAP_W  = $clog2(2001) + 1;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One spare bit so a counter loaded with its maximum never wraps.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/spi_multi_motor_ctrl_tick.sv
// Clock-enable divider: one-clk tick every SCLK_DIVIDER clks while en is high.
module spi_sclk_tick
  import spi_multi_pkg::*;
#(
  parameter int SCLK_DIVIDER = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic tick
);

  localparam int TICK_W = cnt_w(SCLK_DIVIDER);

  logic [TICK_W-1:0] cnt;

  // Held at zero while disabled so the first tick lands SCLK_DIVIDER clks after enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (!en || cnt == TICK_W'(SCLK_DIVIDER - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TICK_W'(1);
    end
  end

  assign tick = en && (cnt == TICK_W'(SCLK_DIVIDER - 1));

endmodule

// File: rtl/spi_multi_motor_ctrl.sv
// Round-robin SPI master refreshing NUM_CH PMD901 drivers over shared sclk/mosi.
// Optional MISO capture is enabled by defining SPI_MISO_CAPTURE_EN.
module spi_multi_motor_ctrl
  import spi_multi_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int DATA_W          = 16,
  parameter int SCLK_DIVIDER    = 8,
  parameter int FRAME_GAP       = 2001,
  parameter int CS_N_HOLD_COUNT = 3
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [ch_w(NUM_CH)-1:0]   wsel,
  input  logic                      we,
  input  logic [NUM_CH-1:0]         dev_enable,
  input  logic [NUM_CH-1:0]         dev_bending,
  input  logic                      miso,
  output logic [NUM_CH-1:0]         park,
  output logic [NUM_CH-1:0]         bending,
  output logic                      sclk,
  output logic [NUM_CH-1:0]         cs_n,
  output logic                      mosi,
  output logic                      frame_done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      rvalid,
  output logic [ch_w(NUM_CH)-1:0]   rch
);

  localparam int CH_W   = ch_w(NUM_CH);
  localparam int GAP_W  = cnt_w(FRAME_GAP);
  localparam int PH_MAX = (CS_N_HOLD_COUNT > 2 * DATA_W) ? CS_N_HOLD_COUNT : 2 * DATA_W;
  localparam int PH_W   = cnt_w(PH_MAX);

  spi_state_e        state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [PH_W-1:0]   ph_cnt;
  logic [DATA_W-1:0] shadow [NUM_CH];
  logic [DATA_W-1:0] shift_q;
  logic [CH_W-1:0]   ch;
  logic              tick;
  logic              last_hold;
  logic              last_shift;
  logic              frame_end;

  spi_sclk_tick #(.SCLK_DIVIDER(SCLK_DIVIDER)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .en   (state != GAP),
    .tick (tick)
  );

  assign last_hold  = (ph_cnt == PH_W'(CS_N_HOLD_COUNT - 1));
  assign last_shift = (ph_cnt == PH_W'(2 * DATA_W - 1));
  assign frame_end  = (state == HOLD) && tick && last_hold;

  // NOTE: the shadow array is reset explicitly because an unwritten channel must send zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else if (we && (int'(wsel) < NUM_CH)) begin
      shadow[wsel] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      park    <= '0;
      bending <= '0;
    end else begin
      park    <= dev_enable;
      bending <= dev_bending;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= GAP;
      gap_cnt    <= GAP_W'(FRAME_GAP);
      ph_cnt     <= '0;
      shift_q    <= '0;
      ch         <= '0;
      sclk       <= 1'b0;
      cs_n       <= '1;
      mosi       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        GAP: begin
          if (gap_cnt == GAP_W'(1)) begin
            state    <= SETUP;
            shift_q  <= shadow[ch];
            mosi     <= shadow[ch][DATA_W-1];
            cs_n[ch] <= 1'b0;
            ph_cnt   <= '0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        SETUP: begin
          if (tick) begin
            if (last_hold) begin
              state  <= SHIFT;
              ph_cnt <= '0;
            end else begin
              ph_cnt <= ph_cnt + PH_W'(1);
            end
          end
        end
        SHIFT: begin
          if (tick) begin
            sclk <= ~sclk;
            // Falling edge advances mosi, except the last one which leaves the LSB in place.
            if (sclk && last_shift) begin
              state  <= HOLD;
              ph_cnt <= '0;
            end else begin
              if (sclk) begin
                shift_q <= shift_q << 1;
                mosi    <= shift_q[DATA_W-2];
              end
              ph_cnt <= ph_cnt + PH_W'(1);
            end
          end
        end
        HOLD: begin
          if (frame_end) begin
            state      <= GAP;
            gap_cnt    <= GAP_W'(FRAME_GAP);
            cs_n       <= '1;
            mosi       <= 1'b0;
            frame_done <= 1'b1;
            ch         <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);
          end else if (tick) begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end
        default: state <= GAP;
      endcase
    end
  end

`ifdef SPI_MISO_CAPTURE_EN
  logic [DATA_W-1:0] cap_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_q  <= '0;
      rdata  <= '0;
      rch    <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      if (state == SHIFT && tick && !sclk) begin
        cap_q <= {cap_q[DATA_W-2:0], miso};
      end
      if (frame_end) begin
        rdata  <= cap_q;
        rch    <= ch;
        rvalid <= 1'b1;
      end
    end
  end
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign rdata       = '0;
  assign rch         = '0;
  assign rvalid      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_multi_motor_ctrl.sv
// Scoreboard bench: predictor derives frame timing/content from the frame-period arithmetic.
module tb_spi_multi_motor_ctrl;

  localparam int NUM_CH    = 3;
  localparam int DATA_W    = 16;
  localparam int DIV       = 8;
  localparam int GAP_CLKS  = 2001;
  localparam int HOLD      = 3;
  localparam int CH_W      = 2;
  localparam int FRAME_LEN = (2 * HOLD + 2 * DATA_W) * DIV;
  localparam int PERIOD    = FRAME_LEN + GAP_CLKS;

  typedef struct {
    int               ch;
    logic [DATA_W-1:0] data;
    int               start;
  } frame_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [DATA_W-1:0] wdata;
  logic [CH_W-1:0]   wsel;
  logic              we;
  logic [NUM_CH-1:0] dev_enable, dev_bending;
  logic              miso = 1'b0;
  logic [NUM_CH-1:0] park, bending, cs_n;
  logic              sclk, mosi, frame_done, rvalid;
  logic [DATA_W-1:0] rdata;
  logic [CH_W-1:0]   rch;

  spi_multi_motor_ctrl #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SCLK_DIVIDER(DIV),
    .FRAME_GAP(GAP_CLKS), .CS_N_HOLD_COUNT(HOLD)
  ) dut (
    .clk(clk), .rstn(rstn), .wdata(wdata), .wsel(wsel), .we(we),
    .dev_enable(dev_enable), .dev_bending(dev_bending), .miso(miso),
    .park(park), .bending(bending), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .frame_done(frame_done), .rdata(rdata), .rvalid(rvalid), .rch(rch)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int frames_done = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc = 0;
    else       cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: shadow contents and the fixed frame schedule.
  frame_t            exp_q[$];
  logic [DATA_W-1:0] model_shadow [NUM_CH];
  int                next_frame;

  function automatic int frame_start(input int k);
    return GAP_CLKS + k * PERIOD;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) model_shadow[i] = '0;
    next_frame = 0;
    exp_q.delete();
  endtask

  // One clk of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step();
    bit collide;
    @(posedge clk);
    #1;
    collide = 1'b0;
    we = 1'b0;
    if (cyc + 1 == frame_start(next_frame)) begin
      frame_t f;
      f.ch    = next_frame % NUM_CH;
      f.data  = model_shadow[f.ch];
      f.start = cyc + 1;
      exp_q.push_back(f);
      collide = (next_frame == 3) || (next_frame == 6);
      next_frame++;
    end
    if (collide) begin
      we = 1'b1; wsel = '0; wdata = 16'hFFFF;
    end else if ($urandom_range(63) == 0) begin
      we = 1'b1; wsel = CH_W'($urandom_range(3)); wdata = DATA_W'($urandom);
    end
    if (we && int'(wsel) < NUM_CH) model_shadow[wsel] = wdata;
    dev_enable  = NUM_CH'($urandom);
    dev_bending = NUM_CH'($urandom);
  endtask

  // Monitor: slave model plus frame checks against the predicted queue.
  bit                in_frame = 0, prev_valid = 0, prev_sclk = 0, bad_cs = 0;
  logic [NUM_CH-1:0] prev_en, prev_bend, exp_cs;
  logic [DATA_W-1:0] got, slave_word;
  frame_t            cur;
  int                fall_cyc, rises, sbit;

  always @(negedge clk) begin
    bit end_now;
    end_now = 1'b0;
    if (!rstn) begin
      in_frame = 0; prev_valid = 0; prev_sclk = 0; miso = 1'b0;
    end else begin
      if (prev_valid) check("park_bending", {park, bending}, {prev_en, prev_bend});
      prev_en = dev_enable; prev_bend = dev_bending; prev_valid = 1;
      if (!in_frame) begin
        if (cs_n != '1) begin
          in_frame = 1; fall_cyc = cyc; rises = 0; got = '0; bad_cs = 0;
          if (exp_q.size() == 0) begin
            check("frame_expected", 0, 1);
            cur.ch = 0; cur.data = '0; cur.start = cyc;
          end else begin
            cur = exp_q.pop_front();
          end
          exp_cs = '1;
          exp_cs[cur.ch] = 1'b0;
          check("frame_start_cycle", cyc, cur.start);
          check("cs_n_select", cs_n, exp_cs);
          check("mosi_msb_at_setup", mosi, cur.data[DATA_W-1]);
          slave_word = DATA_W'($urandom);
          miso = slave_word[DATA_W-1];
          sbit = DATA_W - 2;
        end
      end else if (cs_n == '1) begin
        end_now = 1'b1;
        in_frame = 0;
        frames_done++;
        check("cs_n_low_clks", cyc - fall_cyc, FRAME_LEN);
        check("sclk_rises", rises, DATA_W);
        check("slave_data", got, cur.data);
        check("cs_n_one_low", bad_cs, 0);
        check("frame_done_at_rise", frame_done, 1);
        check("mosi_sclk_idle", {mosi, sclk}, 2'b00);
`ifdef SPI_MISO_CAPTURE_EN
        check("rvalid_with_done", rvalid, 1);
        check("rdata", rdata, slave_word);
        check("rch", rch, cur.ch);
`else
        check("rvalid_off", {rvalid, rdata, rch}, '0);
`endif
      end else begin
        if (cs_n != exp_cs) bad_cs = 1;
        if (sclk && !prev_sclk) begin
          got = {got[DATA_W-2:0], mosi};
          rises++;
        end
        if (!sclk && prev_sclk && sbit >= 0) begin
          miso = slave_word[sbit];
          sbit--;
        end
      end
      if (!end_now) check("no_stray_pulse", {frame_done, rvalid}, 2'b00);
      prev_sclk = sclk;
    end
  end

  initial begin
    we = 1'b0; wsel = '0; wdata = '0; dev_enable = '0; dev_bending = '0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check("reset_cs_n", cs_n, 3'b111);
    check("reset_sclk_mosi", {sclk, mosi}, 2'b00);
    check("reset_park_bending", {park, bending}, '0);
    check("reset_pulses", {frame_done, rvalid}, 2'b00);
    check("reset_rdata_rch", {rdata, rch}, '0);
    rstn = 1'b1;

    while (cyc < frame_start(12) + 100) step();

    // Frame 12 is between its 5th sclk rise and 5th fall: pull reset mid-frame.
    check("rises_before_reset", rises, 5);
    #2;
    rstn = 1'b0;
    #1;
    check("async_cs_n_release", cs_n, 3'b111);
    check("async_sclk", sclk, 1'b0);
    check("async_no_done", frame_done, 1'b0);
    model_reset();
    we = 1'b0; dev_enable = '0; dev_bending = '0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    while (cyc < frame_start(1) + FRAME_LEN + 10) step();

    check("frames_completed", frames_done, 14);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
